mmmu_arbiter: RTL and testbench

MMMU_ARBITER -- requirements
Module: mmmu_arbiter

---
 rtl/mmmu_types.sv | 18 +
 rtl/mmmu_resp_demux.sv | 51 +++++
 rtl/mmmu_arbiter.sv | 119 +++++++++++
 tb/tb_mmmu_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmmu_types.sv
// mmmu_types: shared dbus packet types, data counter width and arbiter state encoding
package mmmu_types;
    localparam int DATA_CTR_WIDTH = 8;
    typedef enum logic [2:0] {
        META_NONE,
        META_CACHE_RD_REQ,
        META_CACHE_WB,
        META_CACHE_RD_RESP,
        META_SPM_WB,
        META_SPM_WRITE
    } dbus_meta_t;
    typedef struct packed {
        logic        on_chip_req;
        dbus_meta_t  on_chip_meta;
        logic [27:0] rsvd;
    } dbus_pkt_cyc0_t;
    typedef enum logic [2:0] {ARB_IDLE, ARB_HDR, ARB_ADDR, ARB_DATA, ARB_WFIN} arb_state_t;
endpackage

// File: rtl/mmmu_resp_demux.sv
// mmmu_resp_demux: routes inbound bridge words to the cache read-response line or SPM write port
module mmmu_resp_demux
    import mmmu_types::*;
#(
    parameter int SPM_IDX_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arb_vld_i,
    input  logic [31:0]          arb_pkt_i,
    input  dbus_meta_t           arb_type_i,
    output logic                 cache_resp_vld,
    output logic [127:0]         cache_resp_line,
    output logic                 spm_wr_en,
    output logic [SPM_IDX_W-1:0] spm_wr_idx,
    output logic [31:0]          spm_wr_data
);
    logic [2:0]           r_beat;
    logic                 r_run;
    logic [SPM_IDX_W-1:0] r_nxt;
    logic [SPM_IDX_W-1:0] w_idx;
    logic                 w_rd_beat;
    logic                 w_wr_beat;

    assign w_rd_beat = arb_vld_i && arb_type_i == META_CACHE_RD_RESP;
    assign w_wr_beat = arb_vld_i && arb_type_i == META_SPM_WRITE;
    // a write burst restarts at index 0 unless the previous cycle was also an SPM write beat
    assign w_idx     = r_run ? r_nxt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat         <= '0;
            r_run          <= 1'b0;
            cache_resp_vld <= 1'b0;
            spm_wr_en      <= 1'b0;
        end else begin
            cache_resp_vld <= w_rd_beat && r_beat == 3'd4;
            if (w_rd_beat) begin
                r_beat <= r_beat == 3'd4 ? 3'd0 : r_beat + 3'd1;
                if (r_beat != 3'd0) cache_resp_line[{r_beat[1:0] - 2'd1, 5'd0} +: 32] <= arb_pkt_i;
            end
            r_run     <= w_wr_beat;
            spm_wr_en <= w_wr_beat;
            if (w_wr_beat) begin
                spm_wr_idx  <= w_idx;
                spm_wr_data <= arb_pkt_i;
                r_nxt       <= w_idx + SPM_IDX_W'(1);
            end
        end
    end
endmodule

// File: rtl/mmmu_arbiter.sv
// mmmu_arbiter: round-robin cache/SPM arbiter for the outbound dbus bridge plus inbound response routing
module mmmu_arbiter
    import mmmu_types::*;
#(
    parameter int SPM_IDX_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cache_req_vld,
    input  logic                      cache_req_wb,
    input  logic [31:0]               cache_req_addr,
    input  logic [127:0]              cache_req_line,
    output logic                      cache_req_rdy,
    input  logic                      spm_req_vld,
    input  logic [31:0]               spm_req_addr,
    output logic                      spm_req_rdy,
    input  logic [DATA_CTR_WIDTH-1:0] spm_out_len,
    output logic                      spm_rd_en,
    output logic [SPM_IDX_W-1:0]      spm_rd_idx,
    input  logic [31:0]               spm_rd_data,
    output logic                      arb_vld_o,
    output logic [31:0]               arb_pkt_o,
    input  logic                      arb_ack,
    input  logic                      arb_fin,
    input  logic                      arb_vld_i,
    input  logic [31:0]               arb_pkt_i,
    input  dbus_meta_t                arb_type_i,
    output logic                      cache_resp_vld,
    output logic [127:0]              cache_resp_line,
    output logic                      spm_wr_en,
    output logic [SPM_IDX_W-1:0]      spm_wr_idx,
    output logic [31:0]               spm_wr_data
);
    arb_state_t                r_state, w_next;
    logic                      r_pri_spm, r_is_spm, r_cache_rdy, r_spm_rdy;
    dbus_meta_t                r_meta;
    logic [31:0]               r_addr;
    logic [127:0]              r_line;
    logic [DATA_CTR_WIDTH-1:0] r_len, r_cnt;
    logic [SPM_IDX_W-1:0]      r_rd_idx;
    logic                      w_any, w_gnt_spm, w_last;
    dbus_pkt_cyc0_t            w_hdr;

    assign w_any         = cache_req_vld || spm_req_vld;
    assign w_gnt_spm     = spm_req_vld && (!cache_req_vld || r_pri_spm);
    assign w_last        = r_cnt == (r_is_spm ? r_len : DATA_CTR_WIDTH'(3));
    assign w_hdr         = '{on_chip_req: 1'b1, on_chip_meta: r_meta, rsvd: '0};
    assign cache_req_rdy = r_cache_rdy;
    assign spm_req_rdy   = r_spm_rdy;
    assign spm_rd_idx    = r_rd_idx;

    always_comb begin
        w_next    = r_state;
        arb_vld_o = 1'b0;
        arb_pkt_o = '0;
        spm_rd_en = 1'b0;
        case (r_state)
            ARB_IDLE: w_next = w_any ? ARB_HDR : ARB_IDLE;
            ARB_HDR: begin
                arb_vld_o = 1'b1;
                arb_pkt_o = w_hdr;
                w_next    = arb_ack ? ARB_ADDR : ARB_HDR;
            end
            ARB_ADDR: begin
                arb_pkt_o = r_addr;
                spm_rd_en = r_is_spm;
                w_next    = r_meta == META_CACHE_RD_REQ ? ARB_WFIN : ARB_DATA;
            end
            ARB_DATA: begin
                // SPM data arrives one cycle after its read, so the final word needs no read
                arb_pkt_o = r_is_spm ? spm_rd_data : r_line[{r_cnt[1:0], 5'd0} +: 32];
                spm_rd_en = r_is_spm && !w_last;
                w_next    = w_last ? ARB_WFIN : ARB_DATA;
            end
            default: ;
        endcase
        if (arb_fin) w_next = ARB_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_pri_spm   <= 1'b0;
            r_cache_rdy <= 1'b0;
            r_spm_rdy   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cache_rdy <= 1'b0;
            r_spm_rdy   <= 1'b0;
            if (r_state == ARB_IDLE && w_next == ARB_HDR) begin
                r_pri_spm   <= !w_gnt_spm;
                r_is_spm    <= w_gnt_spm;
                r_cache_rdy <= !w_gnt_spm;
                r_spm_rdy   <= w_gnt_spm;
                r_meta      <= w_gnt_spm ? META_SPM_WB : (cache_req_wb ? META_CACHE_WB : META_CACHE_RD_REQ);
                r_addr      <= w_gnt_spm ? spm_req_addr : cache_req_addr;
                r_line      <= cache_req_line;
                r_len       <= spm_out_len;
                r_cnt       <= '0;
                r_rd_idx    <= '0;
            end
            if (r_state == ARB_DATA) r_cnt <= r_cnt + DATA_CTR_WIDTH'(1);
            if (spm_rd_en) r_rd_idx <= r_rd_idx + SPM_IDX_W'(1);
        end
    end

    mmmu_resp_demux #(.SPM_IDX_W(SPM_IDX_W)) u_resp_demux (
        .clk             (clk),
        .rst             (rst),
        .arb_vld_i       (arb_vld_i),
        .arb_pkt_i       (arb_pkt_i),
        .arb_type_i      (arb_type_i),
        .cache_resp_vld  (cache_resp_vld),
        .cache_resp_line (cache_resp_line),
        .spm_wr_en       (spm_wr_en),
        .spm_wr_idx      (spm_wr_idx),
        .spm_wr_data     (spm_wr_data)
    );
endmodule

// File: tb/tb_mmmu_arbiter.sv
// tb_mmmu_arbiter: randomized bench with bridge and SPM models checked against a transaction-level reference
module tb_mmmu_arbiter;
    import mmmu_types::*;
    localparam int IW = 10;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      cache_req_vld = 1'b0, cache_req_wb = 1'b0;
    logic [31:0]               cache_req_addr = '0;
    logic [127:0]              cache_req_line = '0;
    logic                      cache_req_rdy;
    logic                      spm_req_vld = 1'b0;
    logic [31:0]               spm_req_addr = '0;
    logic                      spm_req_rdy;
    logic [DATA_CTR_WIDTH-1:0] spm_out_len = '0;
    logic                      spm_rd_en;
    logic [IW-1:0]             spm_rd_idx;
    logic [31:0]               spm_rd_data = '0;
    logic                      arb_vld_o;
    logic [31:0]               arb_pkt_o;
    logic                      arb_ack = 1'b0, arb_fin = 1'b0;
    logic                      arb_vld_i = 1'b0;
    logic [31:0]               arb_pkt_i = '0;
    dbus_meta_t                arb_type_i = META_NONE;
    logic                      cache_resp_vld;
    logic [127:0]              cache_resp_line;
    logic                      spm_wr_en;
    logic [IW-1:0]             spm_wr_idx;
    logic [31:0]               spm_wr_data;

    int          n_chk = 0, n_fail = 0;
    int          last_owner = -1;
    logic [31:0] spm_mem [0:255];

    mmmu_arbiter #(.SPM_IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .cache_req_vld(cache_req_vld), .cache_req_wb(cache_req_wb),
        .cache_req_addr(cache_req_addr), .cache_req_line(cache_req_line),
        .cache_req_rdy(cache_req_rdy),
        .spm_req_vld(spm_req_vld), .spm_req_addr(spm_req_addr), .spm_req_rdy(spm_req_rdy),
        .spm_out_len(spm_out_len), .spm_rd_en(spm_rd_en), .spm_rd_idx(spm_rd_idx),
        .spm_rd_data(spm_rd_data),
        .arb_vld_o(arb_vld_o), .arb_pkt_o(arb_pkt_o), .arb_ack(arb_ack), .arb_fin(arb_fin),
        .arb_vld_i(arb_vld_i), .arb_pkt_i(arb_pkt_i), .arb_type_i(arb_type_i),
        .cache_resp_vld(cache_resp_vld), .cache_resp_line(cache_resp_line),
        .spm_wr_en(spm_wr_en), .spm_wr_idx(spm_wr_idx), .spm_wr_data(spm_wr_data)
    );

    always #5 clk = ~clk;

    // synchronous SPM: data one cycle after the read
    always @(posedge clk) if (spm_rd_en) spm_rd_data <= spm_mem[spm_rd_idx[7:0]];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input bit c, input bit s, input int len);
        if (!c && !s && !cache_req_vld && !spm_req_vld) c = 1'b1;
        if (c && !cache_req_vld) begin
            cache_req_vld  = 1'b1;
            cache_req_wb   = 1'($urandom_range(0, 1));
            cache_req_addr = $urandom;
            cache_req_line = {$urandom, $urandom, $urandom, $urandom};
        end
        if (s && !spm_req_vld) begin
            spm_req_vld  = 1'b1;
            spm_req_addr = $urandom;
            spm_out_len  = DATA_CTR_WIDTH'(len < 0 ? int'($urandom_range(0, 7)) : len);
        end
    endtask

    task automatic do_txn(input int ack_dly);
        int          owner, exp_owner, t;
        dbus_meta_t  m;
        logic [31:0] hdr, addr;
        logic [31:0] words[$];
        exp_owner = (cache_req_vld && spm_req_vld) ? (last_owner == 0 ? 1 : 0) : (spm_req_vld ? 1 : 0);
        t = 0;
        while (!cache_req_rdy && !spm_req_rdy && t < 8) begin
            step();
            t++;
        end
        if (!cache_req_rdy && !spm_req_rdy) begin
            chk("grant_timeout", 0, 1);
            cache_req_vld = 1'b0;
            spm_req_vld   = 1'b0;
            return;
        end
        owner = spm_req_rdy ? 1 : 0;
        chk("grant_owner", owner, exp_owner);
        chk("rdy_onehot", cache_req_rdy && spm_req_rdy, 0);
        last_owner = owner;
        if (owner == 1) begin
            m    = META_SPM_WB;
            addr = spm_req_addr;
            for (int k = 0; k <= int'(spm_out_len); k++) words.push_back(spm_mem[k]);
            spm_req_vld = 1'b0;
        end else begin
            m    = cache_req_wb ? META_CACHE_WB : META_CACHE_RD_REQ;
            addr = cache_req_addr;
            if (cache_req_wb) for (int k = 0; k < 4; k++) words.push_back(cache_req_line[32*k +: 32]);
            cache_req_vld = 1'b0;
        end
        hdr = {1'b1, m, 28'd0};
        for (int d = 0; d <= ack_dly; d++) begin
            chk("hdr_vld", arb_vld_o, 1);
            chk("hdr_pkt", arb_pkt_o, hdr);
            if (d == ack_dly) arb_ack = 1'b1;
            step();
        end
        arb_ack = 1'b0;
        chk("addr_pkt", arb_pkt_o, addr);
        chk("addr_vld", arb_vld_o, 0);
        chk("addr_rd_en", spm_rd_en, owner == 1);
        if (owner == 1) chk("addr_rd_idx", spm_rd_idx, 0);
        step();
        for (int k = 0; k < words.size(); k++) begin
            chk("data_pkt", arb_pkt_o, words[k]);
            chk("data_rd_en", spm_rd_en, owner == 1 && k < words.size() - 1);
            if (owner == 1 && k < words.size() - 1) chk("data_rd_idx", spm_rd_idx, k + 1);
            step();
        end
        chk("wfin_rd_en", spm_rd_en, 0);
        repeat ($urandom_range(0, 3)) step();
        arb_fin = 1'b1;
        step();
        arb_fin = 1'b0;
        chk("idle_vld", arb_vld_o, 0);
    endtask

    task automatic rd_resp(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] ws [4];
        ws = '{w0, w1, w2, w3};
        arb_vld_i  = 1'b1;
        arb_type_i = META_CACHE_RD_RESP;
        arb_pkt_i  = $urandom;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("resp_early", cache_resp_vld, 0);
            chk("resp_no_wr", spm_wr_en, 0);
            arb_pkt_i = ws[k];
        end
        step();
        arb_vld_i = 1'b0;
        chk("resp_vld", cache_resp_vld, 1);
        chk("resp_line", cache_resp_line, {w3, w2, w1, w0});
        step();
        chk("resp_pulse", cache_resp_vld, 0);
    endtask

    task automatic wr_burst(input int n, input bit sep_other_meta);
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            arb_vld_i  = 1'b1;
            arb_type_i = META_SPM_WRITE;
            d          = $urandom;
            arb_pkt_i  = d;
            step();
            chk("wr_en", spm_wr_en, 1);
            chk("wr_idx", spm_wr_idx, k % (1 << IW));
            chk("wr_data", spm_wr_data, d);
        end
        arb_vld_i  = sep_other_meta;
        arb_type_i = META_CACHE_WB;
        arb_pkt_i  = $urandom;
        step();
        chk("wr_gap", spm_wr_en, 0);
        chk("wr_gap_resp", cache_resp_vld, 0);
        arb_vld_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) spm_mem[i] = $urandom;
        repeat (3) step();
        chk("rst_arb_vld", arb_vld_o, 0);
        chk("rst_arb_pkt", arb_pkt_o, 0);
        chk("rst_cache_rdy", cache_req_rdy, 0);
        chk("rst_spm_rdy", spm_req_rdy, 0);
        chk("rst_rd_en", spm_rd_en, 0);
        chk("rst_wr_en", spm_wr_en, 0);
        chk("rst_resp_vld", cache_resp_vld, 0);
        rst = 1'b0;
        raise(1, 0, -1);
        cache_req_wb = 1'b1;
        do_txn(0);
        raise(0, 1, 2);
        do_txn(0);
        repeat (3) begin
            raise(1, 1, -1);
            do_txn($urandom_range(0, 2));
        end
        raise(0, 0, -1);
        do_txn(7);
        repeat (20) begin
            raise(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            do_txn($urandom_range(0, 4));
        end
        repeat (2) if (cache_req_vld || spm_req_vld) do_txn(0);
        raise(1, 0, -1);
        cache_req_wb = 1'b1;
        step();
        chk("rst_case_rdy", cache_req_rdy, 1);
        cache_req_vld = 1'b0;
        arb_ack = 1'b1;
        step();
        arb_ack = 1'b0;
        step();
        chk("rst_case_word0", arb_pkt_o, cache_req_line[31:0]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_owner = -1;
        chk("mid_rst_arb_vld", arb_vld_o, 0);
        chk("mid_rst_arb_pkt", arb_pkt_o, 0);
        chk("mid_rst_cache_rdy", cache_req_rdy, 0);
        chk("mid_rst_spm_rdy", spm_req_rdy, 0);
        chk("mid_rst_rd_en", spm_rd_en, 0);
        chk("mid_rst_wr_en", spm_wr_en, 0);
        chk("mid_rst_resp_vld", cache_resp_vld, 0);
        raise(1, 1, -1);
        do_txn(1);
        repeat (2) if (cache_req_vld || spm_req_vld) do_txn(0);
        rd_resp(32'hA, 32'hB, 32'hC, 32'hD);
        repeat (3) rd_resp($urandom, $urandom, $urandom, $urandom);
        repeat (6) wr_burst($urandom_range(1, 6), 1'($urandom_range(0, 1)));
        wr_burst((1 << IW) + 5, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
